cla_accuracy_sequencer: RTL and testbench
=========================================

CLA_ACCURACY_SEQUENCER -- requirements
Module: cla_accuracy_sequencer

Interface
REQ-001 Parameter NSEG, default 4: number of 4-bit segments; datapath width W = 4*NSEG.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port in_valid, input, 1: operand request valid.
REQ-005 Port in_ready, output, 1: sequencer can accept a request.
REQ-006 Port a, input, W: operand A.
REQ-007 Port b, input, W: operand B.
REQ-008 Port acc_level, input, 3: number of low segments run approximate.
REQ-009 Port ctl_mask, output, NSEG: registered per-segment mode; bit i = 1 means segment i is approximate.
REQ-010 Port sum, output, W: registered result.
REQ-011 Port cout, output, 1: carry out of segment NSEG-1.
REQ-012 Port out_valid, output, 1: result valid.
REQ-013 Port out_ready, input, 1: consumer accepts the result.
REQ-014 Port err_cnt, output, 16: count of inexact results (see Configuration).

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE; in_ready = 1 only in IDLE.
REQ-016 IDLE: on in_valid & in_ready, latch a, b and the mask, clear the carry register, set seg_idx = 0, and go to RUN.
REQ-017 Mask rule: ctl_mask[i] = (i < min(acc_level, NSEG)); acc_level > NSEG clamps to all approximate; acc_level = 0 is fully accurate.
REQ-018 RUN processes one segment per cycle, segment seg_idx, from LSB to MSB.
REQ-019 Accurate segment: {c, s} = x + y + carry_reg, a 5-bit result.
REQ-020 Approximate segment: s = (x + y) mod 16 with carry_reg ignored; c = x[3] & y[3].
REQ-021 s is written to sum[4*seg_idx+3 : 4*seg_idx] and c is written to carry_reg.
REQ-022 After segment NSEG-1: cout = c, then go to DONE; seg_idx does not wrap within RUN.
REQ-023 out_valid = 1 exactly in DONE, and sum/cout are stable while out_valid = 1.
REQ-024 Latency: accept at edge N gives out_valid = 1 after edge N+NSEG (first visible cycle N+NSEG).
REQ-025 DONE with out_ready = 1: go to IDLE at that edge; in_ready = 1 the next cycle, with no same-cycle bypass.
REQ-026 DONE with out_ready = 0: hold indefinitely.
REQ-027 in_valid during RUN/DONE is ignored and not queued; a, b and acc_level are sampled only at acceptance.
REQ-028 ctl_mask holds the mask of the current or last request until the next acceptance.

Reset
REQ-029 rst = 1 at any edge, including mid-RUN, SHALL force IDLE and abort any in-flight operation with no output.
REQ-030 Reset values: in_ready = 1, out_valid = 0, sum = 0, cout = 0, ctl_mask = 0, seg_idx = 0, carry_reg = 0, err_cnt = 0.

Configuration
REQ-031 Macro CLA_SEQ_ERRCNT_EN, when defined:
- an exact W-bit reference sum a + b (with carry) is computed on the latched operands;
- on entering DONE, err_cnt increments by 1 if {cout, sum} differs from the reference;
- err_cnt saturates at 16'hFFFF.
REQ-032 CLA_SEQ_ERRCNT_EN undefined: err_cnt is tied to 0, no reference adder is built, and all other behaviour is identical.

Verification
REQ-033 NSEG = 4, acc_level = 0, a = 16'hFFFF, b = 16'h0001 -> sum = 16'h0000, cout = 1, out_valid in the 4th cycle after acceptance, err_cnt unchanged.
REQ-034 acc_level = 1, a = 16'h000F, b = 16'h0001 -> ctl_mask = 4'b0001, sum = 16'h0000, cout = 0; err_cnt +1 with the macro, 0 without.
REQ-035 acc_level = 7 (clamp), a = b = 16'h8888 -> ctl_mask = 4'b1111, sum = 16'h0000, cout = 1; err_cnt +1 with the macro (exact sum 16'h1110).
REQ-036 Hold out_ready = 0 for 10 cycles in DONE while pulsing in_valid -> sum stable, in_ready = 0, no second request accepted; out_ready = 1 -> in_ready = 1 the next cycle.
REQ-037 Assert rst in the 2nd RUN cycle -> next cycle IDLE, out_valid = 0, sum = 0, err_cnt = 0; a fresh request then completes correctly.
REQ-038 With the macro, run 70000 mismatching requests -> err_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/cla_accuracy_sequencer.sv
// ============================================================================
// cla_accuracy_sequencer : segment-serial adder, low segments approximate
// Optional: CLA_SEQ_ERRCNT_EN adds an exact reference and an inexact counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cla_accuracy_sequencer #(
  parameter int NSEG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NSEG-1:0] a,
  input  logic [4*NSEG-1:0] b,
  input  logic [2:0]        acc_level,
  output logic [NSEG-1:0]   ctl_mask,
  output logic [4*NSEG-1:0] sum,
  output logic              cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       err_cnt
);

  localparam int c_W    = 4 * NSEG;
  localparam int c_IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(NSEG - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [c_W-1:0]    r_a;
  logic [c_W-1:0]    r_b;
  logic [c_W-1:0]    r_sum;
  logic              r_cout;
  logic [NSEG-1:0]   r_mask;
  logic [c_IDXW-1:0] r_seg_idx;
  logic              r_carry;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_last;
  logic [NSEG-1:0]   w_mask;
  logic [3:0]        w_x;
  logic [3:0]        w_y;
  logic [3:0]        w_s;
  logic              w_c;
  logic [c_W-1:0]    w_sum_next;

  // Segment i is approximate when i < acc_level; the clamp falls out naturally.
  generate
    for (genvar i = 0; i < NSEG; i++) begin : g_mask
      assign w_mask[i] = (int'(acc_level) > i);
    end
  endgenerate

  assign w_accept = in_valid && (r_state == c_IDLE);
  assign w_last   = (r_state == c_RUN) && (r_seg_idx == c_LAST);
  assign w_x      = r_a[4*r_seg_idx +: 4];
  assign w_y      = r_b[4*r_seg_idx +: 4];

  always_comb begin
    w_s = w_x + w_y;
    w_c = w_x[3] & w_y[3];
    if (!r_mask[r_seg_idx]) begin
      {w_c, w_s} = {1'b0, w_x} + {1'b0, w_y} + {4'd0, r_carry};
    end
  end

  generate
    for (genvar i = 0; i < NSEG; i++) begin : g_seg
      assign w_sum_next[4*i +: 4] = (r_seg_idx == c_IDXW'(i)) ? w_s : r_sum[4*i +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (in_valid) w_next = c_RUN;
      c_RUN:   if (r_seg_idx == c_LAST) w_next = c_DONE;
      c_DONE:  if (out_ready) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == c_IDLE);
    w_out_valid = (r_state == c_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_mask    <= '0;
      r_seg_idx <= '0;
      r_carry   <= 1'b0;
    end else if (w_accept) begin
      r_a       <= a;
      r_b       <= b;
      r_mask    <= w_mask;
      r_carry   <= 1'b0;
      r_seg_idx <= '0;
    end else if (r_state == c_RUN) begin
      r_sum   <= w_sum_next;
      r_carry <= w_c;
      if (w_last) begin
        r_cout <= w_c;
      end else begin
        r_seg_idx <= r_seg_idx + 1'b1;
      end
    end
  end

`ifdef CLA_SEQ_ERRCNT_EN
  logic [c_W:0] w_ref;
  logic [15:0]  r_err_cnt;

  assign w_ref = {1'b0, r_a} + {1'b0, r_b};

  // Compared on the edge that enters DONE, using the result being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= 16'd0;
    end else if (w_last && ({w_c, w_sum_next} != w_ref) && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 16'd0;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign ctl_mask  = r_mask;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_cla_accuracy_sequencer.sv
// ============================================================================
// tb_cla_accuracy_sequencer : scoreboard bench for cla_accuracy_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cla_accuracy_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic [2:0]  acc_level = 3'd0;
  logic [3:0]  ctl_mask;
  logic [15:0] sum;
  logic        cout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_err = 16'd0;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic [3:0]  mask;
    logic        inexact;
  } exp_t;

  exp_t sb[$];

  cla_accuracy_sequencer #(.NSEG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .acc_level (acc_level),
    .ctl_mask  (ctl_mask),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #20000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] model_add(input logic [15:0] av, input logic [15:0] bv,
                                            input logic [2:0] lv);
    logic [15:0] s;
    logic        c;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [4:0]  t;
    s = 16'd0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = av[4*i +: 4];
      y = bv[4*i +: 4];
      if (i < int'(lv)) begin
        t[3:0] = x + y;
        t[4]   = x[3] & y[3];
      end else begin
        t = {1'b0, x} + {1'b0, y} + {4'd0, c};
      end
      s[4*i +: 4] = t[3:0];
      c = t[4];
    end
    return {c, s};
  endfunction

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [2:0] lv);
    exp_t        e;
    logic [16:0] m;
    logic [16:0] exact;
    int          n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready in_ready=%b expected=1", in_ready);
    end
    a = av;
    b = bv;
    acc_level = lv;
    in_valid = 1'b1;
    m = model_add(av, bv, lv);
    exact = {1'b0, av} + {1'b0, bv};
    e.sum = m[15:0];
    e.cout = m[16];
    e.mask = (lv >= 3'd4) ? 4'hF : 4'((1 << lv) - 1);
    e.inexact = (m != exact);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    acc_level = 3'($urandom);
  endtask

  // Waits for the result, checks it, optionally holds DONE for 'delay' cycles.
  task automatic collect(input int delay, input bit pulse);
    exp_t e;
    int   n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL out_valid_timeout out_valid=%b expected=1", out_valid);
    end
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL latency got=%0d expected=4", n);
    end
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty size=0 expected>0");
      return;
    end
    e = sb.pop_front();
`ifdef CLA_SEQ_ERRCNT_EN
    if (e.inexact && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
`endif
    checks++;
    if (sum !== e.sum) begin
      failures++;
      $display("FAIL sum got=%h expected=%h", sum, e.sum);
    end
    checks++;
    if (cout !== e.cout) begin
      failures++;
      $display("FAIL cout got=%b expected=%b", cout, e.cout);
    end
    checks++;
    if (ctl_mask !== e.mask) begin
      failures++;
      $display("FAIL ctl_mask got=%b expected=%b", ctl_mask, e.mask);
    end
    checks++;
    if (err_cnt !== exp_err) begin
      failures++;
      $display("FAIL err_cnt got=%h expected=%h", err_cnt, exp_err);
    end
    for (int k = 0; k < delay; k++) begin
      if (pulse) begin
        in_valid = k[0];
        a = 16'($urandom);
        b = 16'($urandom);
        acc_level = 3'($urandom);
      end
      @(negedge clk);
      checks++;
      if (sum !== e.sum || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold sum=%h out_valid=%b in_ready=%b expected sum=%h out_valid=1 in_ready=0",
                 sum, out_valid, in_ready, e.sum);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_in_ready got=%b expected=0", in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL release in_ready=%b out_valid=%b expected in_ready=1 out_valid=0",
               in_ready, out_valid);
    end
    checks++;
    if (ctl_mask !== e.mask) begin
      failures++;
      $display("FAIL mask_retained got=%b expected=%b", ctl_mask, e.mask);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'd0 || cout !== 1'b0 ||
        ctl_mask !== 4'd0 || err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state in_ready=%b out_valid=%b sum=%h cout=%b mask=%b err=%h expected 1 0 0000 0 0000 0000",
               in_ready, out_valid, sum, cout, ctl_mask, err_cnt);
    end
  endtask

  task automatic test_accurate_carry();
    send(16'hFFFF, 16'h0001, 3'd0);
    checks++;
    if (sb[0].sum !== 16'h0000 || sb[0].cout !== 1'b1) begin
      failures++;
      $display("FAIL model_accurate got=%h/%b expected=0000/1", sb[0].sum, sb[0].cout);
    end
    collect(0, 1'b0);
  endtask

  task automatic test_approx_level1();
    send(16'h000F, 16'h0001, 3'd1);
    collect(0, 1'b0);
  endtask

  task automatic test_clamp();
    send(16'h8888, 16'h8888, 3'd7);
    collect(0, 1'b0);
  endtask

  task automatic test_hold();
    send(16'h1234, 16'h0FF1, 3'd2);
    collect(10, 1'b1);
    repeat (8) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL no_second_request out_valid=%b in_ready=%b expected out_valid=0 in_ready=1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    send(16'h000F, 16'h0001, 3'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    exp_err = 16'd0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'd0 || cout !== 1'b0 ||
        ctl_mask !== 4'd0 || err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL mid_run_reset in_ready=%b out_valid=%b sum=%h cout=%b mask=%b err=%h expected 1 0 0000 0 0000 0000",
               in_ready, out_valid, sum, cout, ctl_mask, err_cnt);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL aborted_output out_valid=%b expected=0", out_valid);
    end
    send(16'hA5C3, 16'h5A3D, 3'd0);
    collect(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    send(16'h7FFF, 16'h0001, 3'd0);
    collect(0, 1'b0);
    send(16'hFFFF, 16'hFFFF, 3'd3);
    collect(0, 1'b0);
    send(16'h0F0F, 16'hF0F1, 3'd4);
    collect(0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      send(16'($urandom), 16'($urandom), 3'($urandom));
      collect(int'($urandom_range(0, 3)), 1'b1);
    end
  endtask

`ifdef CLA_SEQ_ERRCNT_EN
  task automatic test_saturate();
    for (int i = 0; i < 70000; i++) begin
      send(16'h000F, 16'h0001, 3'd1);
      collect(0, 1'b0);
    end
    checks++;
    if (err_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL err_saturate got=%h expected=ffff", err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_accurate_carry();
    test_approx_level1();
    test_clamp();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
`ifdef CLA_SEQ_ERRCNT_EN
    test_saturate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
